udp_csum_seq: RTL

//  Streaming sequencer for the UDP ones'-complement checksum datapath. Accepts one packet
//  as 32-bit beats over a valid/ready handshake. Folds every beat into a 16-bit end-around-carry

---
 rtl/udp_pkg.sv | 33 +++
 rtl/udp_oc_add16.sv | 17 +
 rtl/udp_csum_seq.sv | 99 +++++++++
 3 files changed

// File: rtl/udp_pkg.sv
// Shared definitions for the UDP checksum sequencer: sequencer states, checksum width
// and the last-beat byte helpers.
package udp_pkg;

  localparam int UDP_CSUM_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  // Unused low bytes of a short last beat are zeroed, so an odd length gets a zero pad byte.
  function automatic logic [31:0] beat_mask(input logic [1:0] nbytes, input logic last);
    logic [31:0] m;
    m = 32'hFFFF_FFFF;
    if (last) begin
      unique case (nbytes)
        2'd1:    m = 32'hFF00_0000;
        2'd2:    m = 32'hFFFF_0000;
        2'd3:    m = 32'hFFFF_FF00;
        default: m = 32'hFFFF_FFFF;
      endcase
    end
    return m;
  endfunction

  function automatic logic [2:0] beat_bytes(input logic [1:0] nbytes, input logic last);
    return (last && nbytes != 2'd0) ? {1'b0, nbytes} : 3'd4;
  endfunction

endpackage

// File: rtl/udp_oc_add16.sv
// Combinational 16-bit ones'-complement adder: the carry out of the 17-bit sum is
// wrapped back into bit 0.
module udp_oc_add16
  import udp_pkg::*;
(
  input  logic [UDP_CSUM_W-1:0] a_i,
  input  logic [UDP_CSUM_W-1:0] b_i,
  output logic [UDP_CSUM_W-1:0] sum_o
);

  logic [UDP_CSUM_W:0] raw;

  assign raw = {1'b0, a_i} + {1'b0, b_i};
  // A wrapped carry can never overflow again: the largest raw sum is 17'h1FFFE.
  assign sum_o = raw[UDP_CSUM_W-1:0] + {{(UDP_CSUM_W-1){1'b0}}, raw[UDP_CSUM_W]};

endmodule

// File: rtl/udp_csum_seq.sv
// UDP checksum sequencer: folds 32-bit beats into a seeded ones'-complement sum, then
// presents the complemented checksum, length and oversize flag on a held result handshake.
module udp_csum_seq
  import udp_pkg::*;
#(
  parameter logic [15:0] MAX_BYTES  = 16'd1472,
  parameter bit          ZERO_SUBST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  input  logic [31:0] s_data,
  input  logic [1:0]  s_bytes,
  input  logic        s_last,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] cs_data,
  output logic [15:0] cs_len,
  output logic        cs_err,
  output logic        cs_valid,
  input  logic        cs_ready
);

  state_e      state_q;
  logic [15:0] acc_q, len_q, cs_data_q, cs_len_q;
  logic        s_ready_q, cs_valid_q, cs_err_q;

  logic        beat_fire;
  logic [31:0] beat;
  logic [15:0] acc_base, sum_hi, sum_lo, len_base, len_d, fold_d;
  logic [16:0] len_sum;

  assign beat_fire = s_valid & s_ready_q;
  assign beat      = s_data & beat_mask(s_bytes, s_last);
  // The first beat of a packet starts from the seed rather than the accumulator.
  assign acc_base  = (state_q == IDLE) ? seed : acc_q;
  assign len_base  = (state_q == IDLE) ? 16'd0 : len_q;
  assign len_sum   = {1'b0, len_base} + {14'd0, beat_bytes(s_bytes, s_last)};
  assign len_d     = len_sum[16] ? 16'hFFFF : len_sum[15:0];
  assign fold_d    = (ZERO_SUBST && acc_q == 16'hFFFF) ? 16'hFFFF : ~acc_q;

  udp_oc_add16 u_add_hi (.a_i(acc_base), .b_i(beat[31:16]), .sum_o(sum_hi));
  udp_oc_add16 u_add_lo (.a_i(sum_hi),   .b_i(beat[15:0]),  .sum_o(sum_lo));

  // NOTE: every register here is state, so all updates are non-blocking; the async
  // reset branch covers every register so no value depends on power-up contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      len_q      <= '0;
      s_ready_q  <= 1'b0;
      cs_valid_q <= 1'b0;
      cs_data_q  <= '0;
      cs_len_q   <= '0;
      cs_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, ACC: begin
          s_ready_q <= 1'b1;
          if (beat_fire) begin
            acc_q <= sum_lo;
            len_q <= len_d;
            if (s_last) begin
              state_q   <= FOLD;
              s_ready_q <= 1'b0;
            end else begin
              state_q <= ACC;
            end
          end else if (state_q == IDLE) begin
            acc_q <= seed;
          end
        end
        FOLD: begin
          cs_data_q  <= fold_d;
          cs_len_q   <= len_q;
          cs_err_q   <= (len_q > MAX_BYTES);
          cs_valid_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          if (cs_ready) begin
            cs_valid_q <= 1'b0;
            s_ready_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready  = s_ready_q;
  assign cs_data  = cs_data_q;
  assign cs_len   = cs_len_q;
  assign cs_err   = cs_err_q;
  assign cs_valid = cs_valid_q;

endmodule
